chime_ctrl: RTL and testbench

Tone-request controller for the digital clock: decides, second by second, when the buzzer sounds and at which pitch. It produces `en_500` / `en_1k`, which feed the tone drive stage that gates the 500 Hz / 1 kHz carriers. It implements the hourly chime and a snoozable alarm. The hourly chime is four 500 Hz beeps at 59:51/53/55/57 and a 1 kHz beep at 59:59.

---
 rtl/chime_pkg.sv | 37 +++
 rtl/chime_decode.sv | 38 +++
 rtl/chime_ctrl.sv | 168 ++++++++++++++++
 tb/tb_chime_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chime_pkg.sv
// Shared types and constants for the clock chime / alarm controller.
// State encoding, BCD match constants and counter sizing helpers.
package chime_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    // Hourly chime fires during minute 59
    localparam logic [3:0] CHIME_MIN_T = 4'd5;
    localparam logic [3:0] CHIME_MIN_O = 4'd9;

    // Chime seconds 51/53/55/57 (low) and 59 (high)
    localparam logic [3:0] CHIME_SEC_T  = 4'd5;
    localparam logic [3:0] CHIME_SEC_O1 = 4'd1;
    localparam logic [3:0] CHIME_SEC_O3 = 4'd3;
    localparam logic [3:0] CHIME_SEC_O5 = 4'd5;
    localparam logic [3:0] CHIME_SEC_O7 = 4'd7;
    localparam logic [3:0] CHIME_SEC_O9 = 4'd9;

    localparam logic [3:0] BCD_ZERO = 4'd0;
    localparam logic [3:0] BCD_MAX  = 4'd9;

    // Bits needed to hold values 0..max(a, b)
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    function automatic logic bcd_ok(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/chime_decode.sv
// Hourly chime decoder: flags the 500 Hz and 1 kHz chime seconds.
// Ports: chime_en, min_t/min_o/sec_t/sec_o (BCD) in; chime_lo/chime_hi out.
module chime_decode
    import chime_pkg::*;
(
    input  logic       chime_en,
    input  logic [3:0] min_t,
    input  logic [3:0] min_o,
    input  logic [3:0] sec_t,
    input  logic [3:0] sec_o,
    output logic       chime_lo,
    output logic       chime_hi
);

    logic at_slot;

    assign at_slot = chime_en
                  && (min_t == CHIME_MIN_T)
                  && (min_o == CHIME_MIN_O)
                  && (sec_t == CHIME_SEC_T);

    // Out-of-range digits fall into default and never chime
    always_comb begin
        chime_lo = 1'b0;
        chime_hi = 1'b0;
        if (at_slot) begin
            unique case (sec_o)
                CHIME_SEC_O1,
                CHIME_SEC_O3,
                CHIME_SEC_O5,
                CHIME_SEC_O7: chime_lo = 1'b1;
                CHIME_SEC_O9: chime_hi = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/chime_ctrl.sv
// Tone-request controller: hourly chime plus snoozable alarm FSM.
// Ports: clk, rst_n, sec_tick, time/alarm BCD, alm_en, chime_en, stop,
// snooze in; en_500, en_1k, alarm_active out (all registered).
module chime_ctrl
    import chime_pkg::*;
#(
    parameter int ALARM_SECS  = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic [3:0] hr_t,
    input  logic [3:0] hr_o,
    input  logic [3:0] min_t,
    input  logic [3:0] min_o,
    input  logic [3:0] sec_t,
    input  logic [3:0] sec_o,
    input  logic [3:0] alm_hr_t,
    input  logic [3:0] alm_hr_o,
    input  logic [3:0] alm_min_t,
    input  logic [3:0] alm_min_o,
    input  logic       alm_en,
    input  logic       chime_en,
    input  logic       stop,
    input  logic       snooze,
    output logic       en_500,
    output logic       en_1k,
    output logic       alarm_active
);

    localparam int CW = cnt_width(ALARM_SECS, SNOOZE_SECS);
    localparam int SW = cnt_width(MAX_SNOOZE, 0);

    localparam logic [CW-1:0] RING_END = CW'(ALARM_SECS);
    localparam logic [CW-1:0] SNZ_END  = CW'(SNOOZE_SECS);
    localparam logic [SW-1:0] SNZ_MAX  = SW'(MAX_SNOOZE);

    state_t        state, state_n;
    logic [CW-1:0] sec_cnt, cnt_n, cnt_inc;
    logic [SW-1:0] snz_cnt, snz_n;

    logic chime_lo, chime_hi;
    logic chime_lo_q, chime_hi_q;
    logic chime_lo_n, chime_hi_n;
    logic alarm_hit;
    logic en_500_d, en_1k_d, active_d;

    chime_decode u_decode (
        .chime_en (chime_en),
        .min_t    (min_t),
        .min_o    (min_o),
        .sec_t    (sec_t),
        .sec_o    (sec_o),
        .chime_lo (chime_lo),
        .chime_hi (chime_hi)
    );

    // Invalid digits on either side never count as a match
    assign alarm_hit = bcd_ok(hr_t) && bcd_ok(hr_o)
                    && bcd_ok(min_t) && bcd_ok(min_o)
                    && (hr_t == alm_hr_t) && (hr_o == alm_hr_o)
                    && (min_t == alm_min_t) && (min_o == alm_min_o)
                    && (sec_t == BCD_ZERO) && (sec_o == BCD_ZERO);

    assign cnt_inc = sec_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sec_cnt    <= '0;
            snz_cnt    <= '0;
            chime_lo_q <= 1'b0;
            chime_hi_q <= 1'b0;
        end else begin
            state      <= state_n;
            sec_cnt    <= cnt_n;
            snz_cnt    <= snz_n;
            chime_lo_q <= chime_lo_n;
            chime_hi_q <= chime_hi_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = sec_cnt;
        snz_n   = snz_cnt;
        if (!alm_en) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sec_tick && alarm_hit && !stop) begin
                        state_n = RING;
                        cnt_n   = '0;
                        snz_n   = '0;
                    end
                end
                RING: begin
                    if (stop) begin
                        state_n = IDLE;
                    end else if (snooze) begin
                        if (snz_cnt < SNZ_MAX) begin
                            state_n = SNOOZE;
                            cnt_n   = '0;
                            snz_n   = snz_cnt + 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (sec_tick) begin
                        if (cnt_inc == RING_END) begin
                            state_n = IDLE;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop) begin
                        state_n = IDLE;
                    end else if (sec_tick) begin
                        if (cnt_inc == SNZ_END) begin
                            state_n = RING;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Chime request is captured once per second. A second that starts
    // in RING, or with a stop key, never chimes even if the alarm
    // is cancelled later in that second.
    always_comb begin
        chime_lo_n = chime_lo_q;
        chime_hi_n = chime_hi_q;
        if (sec_tick) begin
            chime_lo_n = chime_lo && !stop && (state_n != RING);
            chime_hi_n = chime_hi && !stop && (state_n != RING);
        end
        if (state_n == RING) begin
            en_1k_d  = !cnt_n[0];
            en_500_d = cnt_n[0];
        end else begin
            en_1k_d  = chime_hi_n;
            en_500_d = chime_lo_n;
        end
        active_d = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_500       <= 1'b0;
            en_1k        <= 1'b0;
            alarm_active <= 1'b0;
        end else begin
            en_500       <= en_500_d;
            en_1k        <= en_1k_d;
            alarm_active <= active_d;
        end
    end

endmodule

// File: tb/tb_chime_ctrl.sv
// Directed testbench for chime_ctrl.
// Observed vector is {alarm_active, en_1k, en_500}.
module tb_chime_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sec_tick;
    logic [3:0] hr_t, hr_o, min_t, min_o, sec_t, sec_o;
    logic [3:0] alm_hr_t, alm_hr_o, alm_min_t, alm_min_o;
    logic       alm_en, chime_en, stop, snooze;
    logic       en_500, en_1k, alarm_active;

    localparam logic [2:0] OFF  = 3'b000;
    localparam logic [2:0] C500 = 3'b001;
    localparam logic [2:0] C1K  = 3'b010;
    localparam logic [2:0] R1K  = 3'b110;
    localparam logic [2:0] R500 = 3'b101;
    localparam logic [2:0] SNZ  = 3'b100;

    int total;
    int passed;
    logic [2:0] obs;
    logic [2:0] exp_v;

    chime_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sec_tick     (sec_tick),
        .hr_t         (hr_t),
        .hr_o         (hr_o),
        .min_t        (min_t),
        .min_o        (min_o),
        .sec_t        (sec_t),
        .sec_o        (sec_o),
        .alm_hr_t     (alm_hr_t),
        .alm_hr_o     (alm_hr_o),
        .alm_min_t    (alm_min_t),
        .alm_min_o    (alm_min_o),
        .alm_en       (alm_en),
        .chime_en     (chime_en),
        .stop         (stop),
        .snooze       (snooze),
        .en_500       (en_500),
        .en_1k        (en_1k),
        .alarm_active (alarm_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the next negedge after the tick
    task automatic tick_time(input int h, input int m, input int s);
        hr_t     = 4'(h / 10);
        hr_o     = 4'(h % 10);
        min_t    = 4'(m / 10);
        min_o    = 4'(m % 10);
        sec_t    = 4'(s / 10);
        sec_o    = 4'(s % 10);
        sec_tick = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0;
        stop     = 1'b0;
        snooze   = 1'b0;
    endtask

    task automatic press(input logic st, input logic sn);
        stop   = st;
        snooze = sn;
        @(negedge clk);
        stop   = 1'b0;
        snooze = 1'b0;
    endtask

    task automatic set_alarm(input int h, input int m);
        alm_hr_t  = 4'(h / 10);
        alm_hr_o  = 4'(h % 10);
        alm_min_t = 4'(m / 10);
        alm_min_o = 4'(m % 10);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== OFF)
            $display("FAIL reset: got %b want %b", obs, OFF);
        else
            passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== OFF)
            $display("FAIL post_reset: got %b want %b", obs, OFF);
        else
            passed++;
    endtask

    task automatic test_hourly_chime;
        chime_en = 1'b1;
        alm_en   = 1'b0;
        for (int s = 50; s <= 61; s++) begin
            if (s < 60) tick_time(12, 59, s);
            else tick_time(13, 0, s - 60);
            if (s == 51 || s == 53 || s == 55 || s == 57)
                exp_v = C500;
            else if (s == 59)
                exp_v = C1K;
            else
                exp_v = OFF;
            obs = {alarm_active, en_1k, en_500};
            total++;
            if (obs !== exp_v)
                $display("FAIL chime s=%0d: got %b want %b",
                         s, obs, exp_v);
            else
                passed++;
            if (s == 57) begin
                repeat (4) @(negedge clk);
                obs = {alarm_active, en_1k, en_500};
                total++;
                if (obs !== C500)
                    $display("FAIL chime_hold: got %b want %b",
                             obs, C500);
                else
                    passed++;
            end
        end
        chime_en = 1'b0;
    endtask

    task automatic test_alarm_autostop;
        set_alarm(7, 30);
        alm_en = 1'b1;
        tick_time(7, 29, 59);
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== OFF)
            $display("FAIL pre_alarm: got %b want %b", obs, OFF);
        else
            passed++;
        for (int s = 0; s < 60; s++) begin
            tick_time(7, 30, s);
            exp_v = (s % 2 == 0) ? R1K : R500;
            obs = {alarm_active, en_1k, en_500};
            total++;
            if (obs !== exp_v)
                $display("FAIL ring s=%0d: got %b want %b",
                         s, obs, exp_v);
            else
                passed++;
        end
        tick_time(7, 31, 0);
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== OFF)
            $display("FAIL autostop: got %b want %b", obs, OFF);
        else
            passed++;
        tick_time(7, 31, 1);
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== OFF)
            $display("FAIL after_stop: got %b want %b", obs, OFF);
        else
            passed++;
    endtask

    task automatic test_snooze_limit;
        int t;
        t = 0;
        set_alarm(6, 0);
        alm_en = 1'b1;
        for (int s = 0; s <= 5; s++) begin
            tick_time(6, 0, t % 60);
            t++;
        end
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== R500)
            $display("FAIL ring_s5: got %b want %b", obs, R500);
        else
            passed++;
        for (int k = 1; k <= 3; k++) begin
            press(1'b0, 1'b1);
            obs = {alarm_active, en_1k, en_500};
            total++;
            if (obs !== SNZ)
                $display("FAIL snooze%0d: got %b want %b",
                         k, obs, SNZ);
            else
                passed++;
            for (int n = 1; n <= 300; n++) begin
                tick_time(6 + (t / 3600), (t / 60) % 60, t % 60);
                t++;
                if (k == 1 && n == 100) begin
                    press(1'b0, 1'b1);
                    obs = {alarm_active, en_1k, en_500};
                    total++;
                    if (obs !== SNZ)
                        $display("FAIL snz_ignored: got %b want %b",
                                 obs, SNZ);
                    else
                        passed++;
                end
                if (n == 299) begin
                    obs = {alarm_active, en_1k, en_500};
                    total++;
                    if (obs !== SNZ)
                        $display("FAIL snz_299 k=%0d: got %b want %b",
                                 k, obs, SNZ);
                    else
                        passed++;
                end
            end
            obs = {alarm_active, en_1k, en_500};
            total++;
            if (obs !== R1K)
                $display("FAIL resume%0d: got %b want %b",
                         k, obs, R1K);
            else
                passed++;
        end
        press(1'b0, 1'b1);
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== OFF)
            $display("FAIL snooze4: got %b want %b", obs, OFF);
        else
            passed++;
    endtask

    task automatic test_collisions;
        set_alarm(8, 0);
        alm_en = 1'b1;
        tick_time(8, 0, 0);
        tick_time(8, 0, 1);
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== R500)
            $display("FAIL col_ring: got %b want %b", obs, R500);
        else
            passed++;
        press(1'b1, 1'b1);
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== OFF)
            $display("FAIL stop_snooze: got %b want %b", obs, OFF);
        else
            passed++;
        tick_time(8, 0, 2);
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== OFF)
            $display("FAIL no_retrig: got %b want %b", obs, OFF);
        else
            passed++;
        set_alarm(8, 1);
        tick_time(8, 1, 0);
        stop = 1'b1;
        tick_time(8, 1, 1);
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== OFF)
            $display("FAIL stop_tick: got %b want %b", obs, OFF);
        else
            passed++;
        set_alarm(8, 5);
        tick_time(8, 5, 0);
        alm_en = 1'b0;
        @(negedge clk);
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== OFF)
            $display("FAIL alm_en_off: got %b want %b", obs, OFF);
        else
            passed++;
        alm_en = 1'b1;
        alm_hr_t = 4'd0;
        alm_hr_o = 4'hC;
        alm_min_t = 4'd0;
        alm_min_o = 4'd0;
        hr_t = 4'd0;
        hr_o = 4'hC;
        min_t = 4'd0;
        min_o = 4'd0;
        sec_t = 4'd0;
        sec_o = 4'd0;
        sec_tick = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0;
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== OFF)
            $display("FAIL bad_bcd: got %b want %b", obs, OFF);
        else
            passed++;
    endtask

    task automatic test_chime_suppress;
        set_alarm(10, 59);
        alm_en   = 1'b1;
        chime_en = 1'b1;
        for (int s = 0; s < 60; s++) begin
            tick_time(10, 59, s);
            exp_v = (s % 2 == 0) ? R1K : R500;
            if (s == 0 || s == 51 || s == 52 || s == 59) begin
                obs = {alarm_active, en_1k, en_500};
                total++;
                if (obs !== exp_v)
                    $display("FAIL suppress s=%0d: got %b want %b",
                             s, obs, exp_v);
                else
                    passed++;
            end
        end
        tick_time(11, 0, 0);
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== OFF)
            $display("FAIL suppress_end: got %b want %b", obs, OFF);
        else
            passed++;
        chime_en = 1'b0;
    endtask

    task automatic test_reset_mid_ring;
        set_alarm(9, 15);
        alm_en = 1'b1;
        tick_time(9, 15, 0);
        tick_time(9, 15, 1);
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== R500)
            $display("FAIL pre_rst: got %b want %b", obs, R500);
        else
            passed++;
        #1;
        rst_n = 1'b0;
        #1;
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== OFF)
            $display("FAIL async_rst: got %b want %b", obs, OFF);
        else
            passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick_time(9, 15, 2);
        tick_time(9, 15, 3);
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== OFF)
            $display("FAIL no_resume: got %b want %b", obs, OFF);
        else
            passed++;
        tick_time(9, 15, 0);
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== R1K)
            $display("FAIL rematch: got %b want %b", obs, R1K);
        else
            passed++;
        press(1'b1, 1'b0);
        obs = {alarm_active, en_1k, en_500};
        total++;
        if (obs !== OFF)
            $display("FAIL final_stop: got %b want %b", obs, OFF);
        else
            passed++;
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        rst_n     = 1'b0;
        sec_tick  = 1'b0;
        stop      = 1'b0;
        snooze    = 1'b0;
        alm_en    = 1'b0;
        chime_en  = 1'b0;
        hr_t      = 4'd0;
        hr_o      = 4'd0;
        min_t     = 4'd0;
        min_o     = 4'd0;
        sec_t     = 4'd0;
        sec_o     = 4'd0;
        set_alarm(0, 0);
        test_reset;
        test_hourly_chime;
        test_alarm_autostop;
        test_snooze_limit;
        test_collisions;
        test_chime_suppress;
        test_reset_mid_ring;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
